seg_scan_decoder: RTL
=====================

# seg_scan_decoder

Reconstructs the eight displayed digits from the multiplexed seven-segment bus (`seg`/`an`) that the digital clock top drives to the board display. It sits on the display side of that bus and is the inverse of the clock's scan/encode path. Each complete scan frame yields a 32-bit BCD image for self-check, readback and bench scoreboarding. It also flags illegal segment patterns, multiple active anodes and a stalled scan.

## Interface
- `STABLE_CYCLES`, 4: consecutive identical samples required before a digit is captured (≥2).
- `TIMEOUT_CYCLES`, 4096: cycles without any capture before `scan_lost` asserts.

- `clk`  in  1  system clock, single clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `seg`  in  7  active-low segments {g,f,e,d,c,b,a}; `seg[0]` is a.
- `an`  in  8  active-low digit enables; `an[i]` selects digit i (digit 0 rightmost).
- `digits`  out  32  frame image; nibble i = digit i (0–9, 4'hE illegal, 4'hF blank).
- `frame_valid`  out  1  one-cycle pulse; `digits`/`frame_err` just updated.
- `frame_err`  out  1  last delivered frame contained an illegal pattern or a multi-anode sample.
- `scan_lost`  out  1  level; no capture for `TIMEOUT_CYCLES` cycles.

## Operation
- `seg`/`an` registered once (`seg_q`/`an_q`); all decisions use the registered copies.
- Decode table (`seg` → value): 7'h40→0, 7'h79→1, 7'h24→2, 7'h30→3, 7'h19→4, 7'h12→5, 7'h02→6, 7'h78→7, 7'h00→8, 7'h10→9, 7'h7F→F (blank). Any other pattern → E and sets the frame error accumulator.
- FSM, three states:
  - IDLE: `an_q` has exactly one zero → SETTLE, stable count = 1.
  - SETTLE: `{an_q,seg_q}` equal to the previous sample → count+1; changed → restart the count (stay SETTLE if there is still exactly one zero, else IDLE). When the count reaches `STABLE_CYCLES`: write the shadow nibble, set mask bit i, go to CAPTURED.
  - CAPTURED: hold until `{an_q,seg_q}` changes, then re-evaluate as in IDLE. Exactly one capture per dwell.
- `an_q` all ones (blanking interval) → IDLE; this is not an error.
- Two or more zeros in `an_q` → IDLE and set the error accumulator.
- Recapture of a digit whose mask bit is already set overwrites the shadow nibble; the mask is unchanged.
- Mask reaches 8'hFF → `digits` ← shadow, `frame_err` ← accumulator, pulse `frame_valid`. Mask and accumulator clear on the same edge.
- Timeout counter:
  - Clears on every capture.
  - On reaching `TIMEOUT_CYCLES`: set `scan_lost`, clear mask and accumulator, and hold the counter (no wrap).
  - The next capture clears `scan_lost`.
  - `digits` is retained through a timeout.

## Timing
- Reset values: `digits`=32'hFFFF_FFFF, `frame_valid`=0, `frame_err`=0, `scan_lost`=0; mask=0, FSM=IDLE, registered inputs=all ones.
- Capture latency: an input pattern first present at edge t is written to the shadow at edge t+`STABLE_CYCLES`. A dwell of `STABLE_CYCLES` cycles is captured; a dwell of `STABLE_CYCLES`−1 cycles is not.
- `frame_valid`/`digits` update one edge after the capture that completes the mask.
- Completion and timeout on the same edge: completion wins, and `scan_lost` stays 0.
- Reset asserted mid-frame: all state returns to reset values immediately; the partial frame is discarded.

## Structure
- Shared package `display_pkg` holds:
  - SEG_0…SEG_9 and SEG_BLANK pattern constants, which are also used by the encoder side.
  - DIG_BLANK=4'hF and DIG_BAD=4'hE.
  - The FSM state enum.
- Sub-module `seg7_decode`: purely combinational, `seg[6:0]` → {value[3:0], illegal}.
- Top holds the input registers, FSM, stable counter, shadow/mask, timeout counter and output registers.

## Test plan
- Scan 12:34:56 as digits 7..0 = F,F,1,2,3,4,5,6, 8 cycles per digit (`STABLE_CYCLES`=4) → after the first full frame, `frame_valid` pulses once, `digits`=32'hFF12_3456, `frame_err`=0.
- Digit 3 dwell of 3 cycles in frame 1, 4 cycles in frame 2 → no `frame_valid` for frame 1; pulse after frame 2.
- Digit 5 driven with `seg`=7'h7E → `digits[23:20]`=4'hE, `frame_err`=1; the next clean frame gives `frame_err`=0.
- `an`=8'hFC held for 10 cycles mid-frame → no capture; `frame_err`=1 on that frame's delivery.
- Scan stopped with `an`=8'hFF for 4096 cycles → `scan_lost`=1 and `digits` unchanged; resuming the scan → `scan_lost`=0 at the first capture, `frame_valid` after 8 further captures.
- `reset` pulled low after 5 captured digits → outputs at reset values; the scan resumed after release delivers a frame only after all 8 digits are recaptured.

Source files
------------

// File: rtl/seg_scan_decoder_pkg.sv
// ----------------------------------------------------------------------------
// display_pkg
// Shared definitions for the seven-segment display path: active-low segment
// patterns (ordered {g,f,e,d,c,b,a}), special digit codes, the scan-decoder
// FSM state type and small anode helpers.
// ----------------------------------------------------------------------------
package display_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] DIG_BLANK = 4'hF;
    localparam logic [3:0] DIG_BAD   = 4'hE;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SETTLE   = 2'd1,
        ST_CAPTURED = 2'd2
    } scan_state_e;

    // Exactly one anode driven (active low).
    function automatic logic an_single(input logic [7:0] an);
        return $onehot(~an);
    endfunction

    // Two or more anodes driven at once.
    function automatic logic an_multi(input logic [7:0] an);
        return !$onehot0(~an);
    endfunction

    // Position of the (single) active-low anode; only meaningful when
    // an_single() is true.
    function automatic logic [2:0] an_index(input logic [7:0] an);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!an[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg_scan_decoder_if.sv
// ----------------------------------------------------------------------------
// seg_scan_decoder_if
// Bundles the multiplexed display bus (seg/an) with the reconstructed frame
// outputs of the scan decoder.
//   master : drives seg/an, observes the decoded frame (scan source / bench)
//   slave  : samples seg/an, produces digits/frame_valid/frame_err/scan_lost
// ----------------------------------------------------------------------------
interface seg_scan_decoder_if;
    logic [6:0]  seg;          // active-low segments {g,f,e,d,c,b,a}
    logic [7:0]  an;           // active-low digit enables, an[0] = rightmost
    logic [31:0] digits;       // nibble i = digit i
    logic        frame_valid;  // one-cycle pulse on frame delivery
    logic        frame_err;    // delivered frame had an illegal/multi-anode sample
    logic        scan_lost;    // no capture for the timeout interval

    modport master (
        output seg, an,
        input  digits, frame_valid, frame_err, scan_lost
    );

    modport slave (
        input  seg, an,
        output digits, frame_valid, frame_err, scan_lost
    );
endinterface

// File: rtl/seg_scan_decoder_decode.sv
// ----------------------------------------------------------------------------
// seg7_decode
// Purely combinational seven-segment pattern decoder.
//   seg_i     : active-low segment pattern {g,f,e,d,c,b,a}
//   value_o   : 0-9, DIG_BLANK for all segments off, DIG_BAD otherwise
//   illegal_o : pattern is neither a digit nor blank
// ----------------------------------------------------------------------------
module seg7_decode
    import display_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] value_o,
    output logic       illegal_o
);

    always_comb begin
        value_o   = DIG_BAD;
        illegal_o = 1'b0;
        unique case (seg_i)
            SEG_0:     value_o = 4'd0;
            SEG_1:     value_o = 4'd1;
            SEG_2:     value_o = 4'd2;
            SEG_3:     value_o = 4'd3;
            SEG_4:     value_o = 4'd4;
            SEG_5:     value_o = 4'd5;
            SEG_6:     value_o = 4'd6;
            SEG_7:     value_o = 4'd7;
            SEG_8:     value_o = 4'd8;
            SEG_9:     value_o = 4'd9;
            SEG_BLANK: value_o = DIG_BLANK;
            default: begin
                value_o   = DIG_BAD;
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// ----------------------------------------------------------------------------
// seg_scan_decoder
// Rebuilds the eight displayed digits from the multiplexed seven-segment bus.
// A digit is captured once per dwell after the bus has been stable for
// STABLE_CYCLES samples; when all eight digits have been seen the shadow
// image is delivered on digits with a one-cycle frame_valid pulse.
//   clk   : system clock
//   reset : asynchronous, active-low
//   dsp   : slave side of seg_scan_decoder_if (seg/an in, frame results out)
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | no single anode active (blanking or multi-anode)
// ST_SETTLE   | single anode active, counting identical samples
// ST_CAPTURED | digit of this dwell captured, waiting for the bus to change
// ----------------------------------------------------------------------------
module seg_scan_decoder
    import display_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              reset,
    seg_scan_decoder_if.slave dsp
);

    localparam int STB_W = $clog2(STABLE_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    // Stability timer counts down the remaining identical samples after the
    // first one; capture happens when it would expire.
    localparam logic [STB_W-1:0] STB_RELOAD = STB_W'(STABLE_CYCLES - 1);
    localparam logic [STB_W-1:0] STB_ONE    = STB_W'(1);
    localparam logic [TMO_W-1:0] TMO_RELOAD = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_ONE    = TMO_W'(1);

    // input registers and previous sample
    logic [6:0]  seg_q;
    logic [7:0]  an_q;
    logic [14:0] prev_q;

    // FSM and timers
    scan_state_e       state_q, state_d;
    logic [STB_W-1:0]  stab_q, stab_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;

    // frame assembly
    logic [31:0] shadow_q, shadow_d;
    logic [7:0]  mask_q, mask_d;
    logic        acc_q, acc_d;

    // outputs
    logic [31:0] digits_q, digits_d;
    logic        frame_valid_q, frame_valid_d;
    logic        frame_err_q, frame_err_d;
    logic        scan_lost_q, scan_lost_d;

    // combinational helpers
    logic [14:0] samp;
    logic        changed;
    logic        single;
    logic        multi;
    logic [2:0]  cap_idx;
    logic        capture;
    logic        complete;
    logic        tmo_hit;
    logic [3:0]  dec_val;
    logic        dec_ill;

    seg7_decode u_dec (
        .seg_i     (seg_q),
        .value_o   (dec_val),
        .illegal_o (dec_ill)
    );

    assign samp     = {an_q, seg_q};
    assign changed  = (samp != prev_q);
    assign single   = an_single(an_q);
    assign multi    = an_multi(an_q);
    assign cap_idx  = an_index(an_q);
    assign complete = (mask_q == 8'hFF);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            stab_q  <= '0;
        end else begin
            state_q <= state_d;
            stab_q  <= stab_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stab_d  = stab_q;
        capture = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (single) begin
                    state_d = ST_SETTLE;
                    stab_d  = STB_RELOAD;
                end
            end
            ST_SETTLE: begin
                if (changed) begin
                    if (single) begin
                        stab_d = STB_RELOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (stab_q == STB_ONE) begin
                    capture = 1'b1;
                    state_d = ST_CAPTURED;
                end else begin
                    stab_d = stab_q - STB_ONE;
                end
            end
            ST_CAPTURED: begin
                if (changed) begin
                    if (single) begin
                        state_d = ST_SETTLE;
                        stab_d  = STB_RELOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------- frame datapath
    // The timeout only fires on a cycle without a capture; a completion on
    // the same edge suppresses scan_lost.
    assign tmo_hit = !capture && (tmo_q == TMO_ONE);

    always_comb begin
        shadow_d      = shadow_q;
        mask_d        = mask_q;
        acc_d         = acc_q;
        digits_d      = digits_q;
        frame_valid_d = 1'b0;
        frame_err_d   = frame_err_q;
        scan_lost_d   = scan_lost_q;
        tmo_d         = tmo_q;

        if (complete) begin
            digits_d      = shadow_q;
            frame_err_d   = acc_q;
            frame_valid_d = 1'b1;
        end

        if (complete || tmo_hit) begin
            mask_d = 8'h00;
            acc_d  = 1'b0;
        end

        if (capture) begin
            shadow_d[4*cap_idx +: 4] = dec_val;
            mask_d[cap_idx]          = 1'b1;
            acc_d                    = acc_d | dec_ill;
            tmo_d                    = TMO_RELOAD;
            scan_lost_d              = 1'b0;
        end else begin
            // counter parks at zero until the next capture
            if (tmo_q != '0) tmo_d = tmo_q - TMO_ONE;
            if (tmo_hit && !complete) scan_lost_d = 1'b1;
        end

        // Errors seen on this edge belong to the frame being assembled next.
        acc_d = acc_d | multi;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg_q         <= SEG_BLANK;
            an_q          <= 8'hFF;
            prev_q        <= {8'hFF, SEG_BLANK};
            shadow_q      <= {8{DIG_BLANK}};
            mask_q        <= 8'h00;
            acc_q         <= 1'b0;
            tmo_q         <= TMO_RELOAD;
            digits_q      <= {8{DIG_BLANK}};
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            scan_lost_q   <= 1'b0;
        end else begin
            seg_q         <= dsp.seg;
            an_q          <= dsp.an;
            prev_q        <= samp;
            shadow_q      <= shadow_d;
            mask_q        <= mask_d;
            acc_q         <= acc_d;
            tmo_q         <= tmo_d;
            digits_q      <= digits_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            scan_lost_q   <= scan_lost_d;
        end
    end

    assign dsp.digits      = digits_q;
    assign dsp.frame_valid = frame_valid_q;
    assign dsp.frame_err   = frame_err_q;
    assign dsp.scan_lost   = scan_lost_q;

endmodule
